writeback_buffer: RTL and testbench



---
 rtl/acc_pkg.sv | 17 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/writeback_buffer.sv | 167 ++++++++++++++++
 tb/tb_writeback_buffer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator datapath blocks: default sizes and the
// writeback buffer FSM encoding.
package acc_pkg;

  localparam int DATA_WIDTH_DEF      = 512;
  localparam int DATA_NUM_DEF        = 64;
  localparam int BURST_LENGTH_DEF    = 4;
  localparam int FIFO_ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata always shows the head word
// while empty is low. Pushes while full and pops while empty are ignored.
module wb_fifo
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_en;
  logic                  rd_en;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign data_cnt = cnt;
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign rdata    = mem[rd_ptr];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Collects result words from the conv engine and ships them to the AXI write
// master as fixed-length bursts, zero-padding the last burst of a layer.
module writeback_buffer
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int DATA_NUM        = DATA_NUM_DEF,
  parameter int BURST_LENGTH    = BURST_LENGTH_DEF,
  parameter int FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_start,
  input  logic                  end_conv,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  in_ready,
  input  logic [63:0]           addr_base,
  output logic                  wmst_req,
  input  logic                  wmst_done,
  output logic [63:0]           addr_offset,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  valid,
  input  logic                  ready,
  output logic                  wb_done,
  output logic                  ovf,
  output wb_state_t             state
);

  localparam int CNT_W = FIFO_ADDR_WIDTH + 1;
  localparam int BC_W  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

  wb_state_t             state_q;
  wb_state_t             state_d;
  logic [31:0]           addr_cnt;
  logic [BC_W-1:0]       beat_cnt;
  logic                  pad;
  logic                  flush_pend;
  logic                  done_seen;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_cnt;

  logic                  beat;
  logic                  burst_go;
  logic                  flush_fin;
  logic                  done_now;
  logic                  idle_start;

  wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .pop      (fifo_pop),
    .wdata    (i_data),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .data_cnt (fifo_cnt)
  );

  assign in_ready    = !fifo_full;
  assign state       = state_q;
  assign idle_start  = (state_q == IDLE) && op_start;
  assign addr_offset = addr_base + (64'(addr_cnt) * 64'(DATA_NUM * BURST_LENGTH));

  // Beat handshake: a beat transfers on any cycle where valid && ready. Once
  // valid is raised with a given tdata, both stay put until that beat is taken.
  always_comb begin
    state_d   = state_q;
    burst_go  = 1'b0;
    flush_fin = 1'b0;
    done_now  = 1'b0;
    valid     = (state_q == STREAM) && (!fifo_empty || pad);
    tdata     = ((state_q == STREAM) && !fifo_empty) ? fifo_head : '0;
    beat      = valid && ready;
    fifo_pop  = beat && !fifo_empty;
    case (state_q)
      IDLE: begin
        if ((fifo_cnt >= CNT_W'(BURST_LENGTH)) || (flush_pend && (fifo_cnt != '0))) begin
          burst_go = 1'b1;
          state_d  = REQ;
        end else if (flush_pend) begin
          flush_fin = 1'b1;
        end
      end
      REQ: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (beat && (beat_cnt == BC_W'(BURST_LENGTH - 1))) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (wmst_done || done_seen) begin
          done_now = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wmst_req   <= 1'b0;
      wb_done    <= 1'b0;
      ovf        <= 1'b0;
      addr_cnt   <= '0;
      beat_cnt   <= '0;
      pad        <= 1'b0;
      flush_pend <= 1'b0;
      done_seen  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wmst_req <= burst_go;
      wb_done  <= flush_fin;

      if (burst_go) begin
        pad <= (fifo_cnt < CNT_W'(BURST_LENGTH));
      end

      if (state_q == REQ) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end

      // A new end_conv re-arms the flush even on the cycle an old one retires.
      if (end_conv) begin
        flush_pend <= 1'b1;
      end else if (flush_fin) begin
        flush_pend <= 1'b0;
      end

      // The write master may commit before the last beat leaves; remember it.
      if (done_now) begin
        done_seen <= 1'b0;
      end else if (wmst_done && ((state_q == REQ) || (state_q == STREAM))) begin
        done_seen <= 1'b1;
      end

      if (done_now) begin
        addr_cnt <= addr_cnt + 32'd1;
      end else if (flush_fin || idle_start) begin
        addr_cnt <= '0;
      end

      if (push_req && fifo_full) begin
        ovf <= 1'b1;
      end else if (idle_start) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: random words and ready patterns,
// expected beat stream built from the pushed words with end-of-layer padding.
`timescale 1ns/1ps
module tb_writeback_buffer;
  import acc_pkg::*;

  localparam int DW     = DATA_WIDTH_DEF;
  localparam int BL     = BURST_LENGTH_DEF;
  localparam int DEPTH  = 1 << FIFO_ADDR_WIDTH_DEF;
  localparam int STRIDE = DATA_NUM_DEF * BURST_LENGTH_DEF;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_start = 1'b0;
  logic          end_conv = 1'b0;
  logic          push_req = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          in_ready;
  logic [63:0]   addr_base = '0;
  logic          wmst_req;
  logic          wmst_done;
  logic [63:0]   addr_offset;
  logic [DW-1:0] tdata;
  logic          valid;
  logic          ready;
  logic          wb_done;
  logic          ovf;
  wb_state_t     state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  writeback_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .op_start    (op_start),
    .end_conv    (end_conv),
    .push_req    (push_req),
    .i_data      (i_data),
    .in_ready    (in_ready),
    .addr_base   (addr_base),
    .wmst_req    (wmst_req),
    .wmst_done   (wmst_done),
    .addr_offset (addr_offset),
    .tdata       (tdata),
    .valid       (valid),
    .ready       (ready),
    .wb_done     (wb_done),
    .ovf         (ovf),
    .state       (state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  int ready_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random
  int done_mode = 0;    // 0 after last beat, 1 early (during STREAM)

  logic [DW-1:0] got_q[$];
  logic [63:0]   req_addr_q[$];
  int unsigned   req_cyc_q[$];
  int            req_cnt = 0;
  int            done_cnt = 0;
  int            wb_done_cnt = 0;
  int            beats_in_burst = 0;
  int            hold_err = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  // Reference model state: words accepted since the test began.
  logic [DW-1:0] pushed_q[$];
  logic [DW-1:0] exp_q[$];
  int            model_occ = 0;

  // ---------------- monitor (sampled mid-cycle) ----------------
  always @(negedge clk) begin
    if (rst) begin
      beats_in_burst = 0;
      stall_prev = 1'b0;
    end else begin
      if (wmst_req) begin
        req_cnt++;
        req_addr_q.push_back(addr_offset);
        req_cyc_q.push_back(cyc);
        beats_in_burst = 0;
      end
      if (wb_done) wb_done_cnt++;
      if (valid && ready) begin
        got_q.push_back(tdata);
        beats_in_burst++;
      end
      if (stall_prev && valid && (tdata !== stall_data)) hold_err++;
      stall_prev = valid && !ready;
      stall_data = tdata;
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        2:       ready = ~ready;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- write-master responder ----------------
  initial begin
    wmst_done = 1'b0;
    forever begin
      @(negedge clk);
      if (wmst_req && !rst) begin
        if (done_mode == 1) begin
          @(posedge clk); #1 wmst_done = 1'b1; done_cnt++;
          @(posedge clk); #1 wmst_done = 1'b0;
        end else begin
          @(posedge clk);
          while (beats_in_burst < BL && !rst) @(posedge clk);
          if (!rst) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 wmst_done = 1'b1; done_cnt++;
            @(posedge clk); #1 wmst_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks / model helpers ----------------
  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic push_words(input int n, output int unsigned last_cyc);
    logic [DW-1:0] w;
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      w = rand_word();
      @(posedge clk); #1;
      push_req = 1'b1;
      i_data = w;
      last_cyc = cyc;
      if (model_occ < DEPTH) begin
        pushed_q.push_back(w);
        model_occ++;
      end
    end
    @(posedge clk); #1;
    push_req = 1'b0;
  endtask

  task automatic pulse_op_start();
    @(posedge clk); #1 op_start = 1'b1;
    @(posedge clk); #1 op_start = 1'b0;
  endtask

  task automatic pulse_end_conv();
    @(posedge clk); #1 end_conv = 1'b1;
    @(posedge clk); #1 end_conv = 1'b0;
  endtask

  task automatic start_test(input bit new_base);
    if (new_base) addr_base = {$urandom(), $urandom()};
    pulse_op_start();
    pushed_q.delete();
    model_occ = 0;
  endtask

  function automatic void build_exp(input bit flush);
    exp_q = pushed_q;
    if (flush) while ((exp_q.size() % BL) != 0) exp_q.push_back('0);
  endfunction

  function automatic int stream_errors(input int start);
    int e;
    e = 0;
    if (got_q.size() - start != exp_q.size()) e++;
    for (int i = 0; i < exp_q.size(); i++)
      if (start + i >= got_q.size() || got_q[start + i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [63:0] req_addr_at(input int idx);
    return (idx < req_addr_q.size()) ? req_addr_q[idx] : 64'hx;
  endfunction

  task automatic wait_done_idle(input int target, input int budget, output bit ok);
    int k;
    k = 0;
    while (!(done_cnt >= target && state == IDLE) && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (k < budget);
  endtask

  task automatic wait_wb_done(input int target, input int budget, output bit ok);
    int k;
    k = 0;
    while (wb_done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (k < budget);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (wmst_req !== 1'b0) $display("FAIL reset_wmst_req: got %b want 0", wmst_req); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
    checks++; if (tdata !== '0) $display("FAIL reset_tdata: got %h want 0", tdata); else passed++;
    checks++; if (wb_done !== 1'b0) $display("FAIL reset_wb_done: got %b want 0", wb_done); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", state); else passed++;
    checks++; if (addr_offset !== addr_base) $display("FAIL reset_addr: got %h want %h", addr_offset, addr_base); else passed++;
  endtask

  task automatic test_single_burst();
    int g, r, d0, err;
    int unsigned last;
    bit ok;
    ready_mode = 1; done_mode = 0;
    start_test(1'b1);
    g = got_q.size(); r = req_cnt; d0 = done_cnt;
    push_words(BL, last);
    wait_done_idle(d0 + 1, 200, ok);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL single_timeout: burst did not complete within 200 cycles"); else passed++;
    checks++; if (req_cnt - r != 1) $display("FAIL single_req_count: got %0d want 1", req_cnt - r); else passed++;
    checks++; if (req_addr_at(r) !== addr_base) $display("FAIL single_addr: got %h want %h", req_addr_at(r), addr_base); else passed++;
    checks++; if (r >= req_cyc_q.size() || req_cyc_q[r] !== last + 2) $display("FAIL single_latency: req cycle %0d want %0d", (r < req_cyc_q.size()) ? req_cyc_q[r] : 0, last + 2); else passed++;
    checks++; if (err !== 0) $display("FAIL single_data: %0d bad beats want 0", err); else passed++;
  endtask

  task automatic test_two_bursts();
    int g, r, d0, err;
    int unsigned last;
    bit ok;
    ready_mode = 1; done_mode = 0;
    start_test(1'b1);
    g = got_q.size(); r = req_cnt; d0 = done_cnt;
    push_words(2 * BL, last);
    wait_done_idle(d0 + 2, 300, ok);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL two_timeout: bursts did not complete within 300 cycles"); else passed++;
    checks++; if (req_cnt - r != 2) $display("FAIL two_req_count: got %0d want 2", req_cnt - r); else passed++;
    checks++; if (req_addr_at(r) !== addr_base) $display("FAIL two_addr0: got %h want %h", req_addr_at(r), addr_base); else passed++;
    checks++; if (req_addr_at(r + 1) !== addr_base + 64'(STRIDE)) $display("FAIL two_addr1: got %h want %h", req_addr_at(r + 1), addr_base + 64'(STRIDE)); else passed++;
    checks++; if (err !== 0) $display("FAIL two_data: %0d bad beats want 0", err); else passed++;
    checks++; if (addr_offset !== addr_base + 64'(2 * STRIDE)) $display("FAIL two_addr_cnt: got %h want %h", addr_offset, addr_base + 64'(2 * STRIDE)); else passed++;
  endtask

  task automatic test_flush_pad();
    int g, r, w0, err;
    int unsigned last;
    bit ok;
    ready_mode = 1; done_mode = 0;
    start_test(1'b1);
    g = got_q.size(); r = req_cnt; w0 = wb_done_cnt;
    push_words(6, last);
    pulse_end_conv();
    wait_wb_done(w0 + 1, 300, ok);
    build_exp(1'b1);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL flush_timeout: no wb_done within 300 cycles"); else passed++;
    checks++; if (req_cnt - r != 2) $display("FAIL flush_req_count: got %0d want 2", req_cnt - r); else passed++;
    checks++; if (req_addr_at(r + 1) !== addr_base + 64'(STRIDE)) $display("FAIL flush_addr1: got %h want %h", req_addr_at(r + 1), addr_base + 64'(STRIDE)); else passed++;
    checks++; if (err !== 0) $display("FAIL flush_data: %0d bad beats want 0", err); else passed++;
    checks++; if (wb_done_cnt - w0 != 1) $display("FAIL flush_wb_done_count: got %0d want 1", wb_done_cnt - w0); else passed++;
    checks++; if (addr_offset !== addr_base) $display("FAIL flush_addr_cnt: got %h want %h", addr_offset, addr_base); else passed++;
  endtask

  task automatic test_ready_toggle();
    int g, d0, h0, err;
    int unsigned last;
    bit ok;
    ready_mode = 2; done_mode = 0;
    start_test(1'b0);
    g = got_q.size(); d0 = done_cnt; h0 = hold_err;
    push_words(2 * BL, last);
    wait_done_idle(d0 + 2, 400, ok);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL toggle_timeout: bursts did not complete within 400 cycles"); else passed++;
    checks++; if (err !== 0) $display("FAIL toggle_data: %0d bad beats want 0", err); else passed++;
    checks++; if (hold_err - h0 != 0) $display("FAIL toggle_hold: tdata changed while stalled %0d times want 0", hold_err - h0); else passed++;
  endtask

  task automatic test_random();
    int g, r, w0, n, err;
    int unsigned last;
    bit ok;
    for (int rep = 0; rep < 4; rep++) begin
      ready_mode = 3; done_mode = 0;
      start_test(1'b1);
      n = $urandom_range(1, 13);
      g = got_q.size(); r = req_cnt; w0 = wb_done_cnt;
      push_words(n, last);
      pulse_end_conv();
      wait_wb_done(w0 + 1, 600, ok);
      build_exp(1'b1);
      err = stream_errors(g);
      checks++; if (!ok) $display("FAIL random_timeout: n=%0d no wb_done within 600 cycles", n); else passed++;
      checks++; if (err !== 0) $display("FAIL random_data: n=%0d %0d bad beats want 0", n, err); else passed++;
      checks++; if (req_cnt - r != (n + BL - 1) / BL) $display("FAIL random_req_count: n=%0d got %0d want %0d", n, req_cnt - r, (n + BL - 1) / BL); else passed++;
      checks++; if (wb_done_cnt - w0 != 1) $display("FAIL random_wb_done_count: got %0d want 1", wb_done_cnt - w0); else passed++;
    end
  endtask

  task automatic test_overflow();
    int g, d0, err, k;
    int unsigned last;
    bit ok;
    ready_mode = 0; done_mode = 0;
    start_test(1'b1);
    g = got_q.size(); d0 = done_cnt;
    push_words(DEPTH, last);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL ovf_in_ready_full: got %b want 0", in_ready); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf); else passed++;
    push_words(1, last);
    @(negedge clk);
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else passed++;
    k = 0;
    while (state != STREAM && k < 50) begin @(negedge clk); k++; end
    pulse_op_start();
    @(negedge clk);
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_op_start_busy: got %b want 1", ovf); else passed++;
    ready_mode = 1;
    wait_done_idle(d0 + DEPTH / BL, 8000, ok);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL ovf_drain_timeout: drain not complete within 8000 cycles"); else passed++;
    checks++; if (err !== 0) $display("FAIL ovf_data: %0d bad beats want 0", err); else passed++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else passed++;
    checks++; if (addr_offset !== addr_base + 64'(DEPTH / BL) * 64'(STRIDE)) $display("FAIL ovf_addr_cnt: got %h want %h", addr_offset, addr_base + 64'(DEPTH / BL) * 64'(STRIDE)); else passed++;
    pulse_op_start();
    @(negedge clk);
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL ovf_in_ready_after: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_early_done();
    int g, d0, err;
    int unsigned last;
    bit ok;
    ready_mode = 1; done_mode = 1;
    start_test(1'b1);
    g = got_q.size(); d0 = done_cnt;
    push_words(BL, last);
    wait_done_idle(d0 + 1, 200, ok);
    repeat (3) @(negedge clk);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok || state !== IDLE) $display("FAIL early_hang: state %0d want IDLE", state); else passed++;
    checks++; if (addr_offset !== addr_base + 64'(STRIDE)) $display("FAIL early_addr_cnt: got %h want %h", addr_offset, addr_base + 64'(STRIDE)); else passed++;
    checks++; if (err !== 0) $display("FAIL early_data: %0d bad beats want 0", err); else passed++;
    done_mode = 0;
  endtask

  task automatic test_reset_mid();
    int g, r, d0, k, err;
    int unsigned last;
    bit ok;
    ready_mode = 0; done_mode = 1;
    start_test(1'b1);
    push_words(BL, last);
    k = 0;
    while (state != STREAM && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (state !== IDLE) $display("FAIL midrst_state: got %0d want IDLE", state); else passed++;
    checks++; if (valid !== 1'b0 || tdata !== '0) $display("FAIL midrst_valid: got valid=%b want 0 and zero tdata", valid); else passed++;
    checks++; if (in_ready !== 1'b1 || ovf !== 1'b0) $display("FAIL midrst_flags: got in_ready=%b ovf=%b want 1/0", in_ready, ovf); else passed++;
    checks++; if (addr_offset !== addr_base) $display("FAIL midrst_addr: got %h want %h", addr_offset, addr_base); else passed++;
    r = req_cnt;
    repeat (10) @(negedge clk);
    checks++; if (req_cnt != r) $display("FAIL midrst_fifo_discard: got %0d new requests want 0", req_cnt - r); else passed++;
    ready_mode = 1; done_mode = 0;
    pushed_q.delete(); model_occ = 0;
    g = got_q.size(); d0 = done_cnt;
    push_words(BL, last);
    wait_done_idle(d0 + 1, 200, ok);
    build_exp(1'b0);
    err = stream_errors(g);
    checks++; if (!ok) $display("FAIL midrst_resume_timeout: burst not complete within 200 cycles"); else passed++;
    checks++; if (err !== 0) $display("FAIL midrst_data: %0d bad beats want 0", err); else passed++;
    checks++; if (req_addr_at(r) !== addr_base) $display("FAIL midrst_req_addr: got %h want %h", req_addr_at(r), addr_base); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    addr_base = {$urandom(), $urandom()};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single_burst();
    test_two_bursts();
    test_flush_pad();
    test_ready_toggle();
    test_random();
    test_overflow();
    test_early_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
